lc4_muldiv_seq: RTL and testbench



---
 rtl/lc4_muldiv_seq_if.sv | 23 ++
 rtl/lc4_muldiv_seq.sv | 137 +++++++++++++
 tb/tb_lc4_muldiv_seq.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/lc4_muldiv_seq_if.sv
// rtl/lc4_muldiv_seq_if.sv - launch/result handshake between pipeline control and the MUL/DIV/MOD sequencer
interface lc4_muldiv_seq_if #(
    parameter int WORD_SIZE = 16
);
    logic                 i_start;
    logic [1:0]           i_op;
    logic [WORD_SIZE-1:0] i_r1data;
    logic [WORD_SIZE-1:0] i_r2data;
    logic                 i_flush;
    logic                 o_busy;
    logic                 o_done;
    logic [WORD_SIZE-1:0] o_result;

    modport master (
        output i_start, i_op, i_r1data, i_r2data, i_flush,
        input  o_busy, o_done, o_result
    );

    modport slave (
        input  i_start, i_op, i_r1data, i_r2data, i_flush,
        output o_busy, o_done, o_result
    );
endinterface

// File: rtl/lc4_muldiv_seq.sv
// rtl/lc4_muldiv_seq.sv - iterative LC4 MUL/DIV/MOD sequencer over one shared adder/subtractor
module lc4_muldiv_seq #(
    parameter int WORD_SIZE = 16
) (
    input logic                clk,
    input logic                rst,
    lc4_muldiv_seq_if.slave    bus
);
    localparam int W  = WORD_SIZE;
    localparam int CW = $clog2(WORD_SIZE + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_DIV = 2'b01;
    localparam logic [1:0] OP_RSV = 2'b11;

    logic [1:0]    state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  result_q, result_d;

    logic [W-1:0]  rem_shift, add_x, add_y;
    logic          add_sub;
    logic [W:0]    add_out;
    logic          no_borrow;
    logic [W-1:0]  acc_n, a_n, b_n, fin;
    logic          launch, start_ok;

    // MUL: acc accumulates a (shifted left) while b is consumed LSB-first.
    // DIV/MOD: acc is the partial remainder, a shifts dividend bits out the top and quotient bits in the bottom.
    always_comb begin
        rem_shift = {acc_q[W-2:0], a_q[W-1]};
        if (op_q == OP_MUL) begin
            add_x   = acc_q;
            add_y   = b_q[0] ? a_q : '0;
            add_sub = 1'b0;
        end else begin
            add_x   = rem_shift;
            add_y   = b_q;
            add_sub = 1'b1;
        end
        add_out = add_sub ? ({1'b0, add_x} - {1'b0, add_y})
                          : ({1'b0, add_x} + {1'b0, add_y});
        // The bit shifted out of acc is the 17th bit of the shifted remainder; when set the subtract cannot borrow.
        no_borrow = acc_q[W-1] | ~add_out[W];

        if (op_q == OP_MUL) begin
            acc_n = add_out[W-1:0];
            a_n   = a_q << 1;
            b_n   = b_q >> 1;
        end else begin
            acc_n = no_borrow ? add_out[W-1:0] : rem_shift;
            a_n   = {a_q[W-2:0], no_borrow};
            b_n   = b_q;
        end
        fin = (op_q == OP_DIV) ? a_n : acc_n;
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        count_d  = count_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;
        start_ok = bus.i_start && !bus.i_flush;
        launch   = 1'b0;

        case (state_q)
            ST_IDLE: launch = start_ok;
            ST_RUN: begin
                if (bus.i_flush) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d   = acc_n;
                    a_d     = a_n;
                    b_d     = b_n;
                    count_d = count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        state_d  = ST_DONE;
                        result_d = fin;
                    end
                end
            end
            ST_DONE: begin
                launch  = start_ok;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (launch) begin
            if (bus.i_op == OP_RSV || (bus.i_op != OP_MUL && bus.i_r2data == '0)) begin
                state_d  = ST_DONE;
                result_d = '0;
            end else begin
                state_d = ST_RUN;
                op_d    = bus.i_op;
                a_d     = bus.i_r1data;
                b_d     = bus.i_r2data;
                acc_d   = '0;
                count_d = CW'(W);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MUL;
            count_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            count_q  <= count_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign bus.o_busy   = (state_q == ST_RUN);
    assign bus.o_done   = (state_q == ST_DONE);
    assign bus.o_result = result_q;
endmodule

// File: tb/tb_lc4_muldiv_seq.sv
// tb/tb_lc4_muldiv_seq.sv - directed bench for lc4_muldiv_seq
module tb_lc4_muldiv_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    lc4_muldiv_seq_if #(.WORD_SIZE(16)) bus ();
    lc4_muldiv_seq #(.WORD_SIZE(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic drive_start(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        bus.i_start  = 1'b1;
        bus.i_op     = op;
        bus.i_r1data = a;
        bus.i_r2data = b;
        @(posedge clk);
        #1;
        bus.i_start  = 1'b0;
        bus.i_op     = 2'b00;
        bus.i_r1data = 16'hDEAD;
        bus.i_r2data = 16'hBEEF;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 || bus.o_result !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset busy=%b done=%b result=%h expected 0 0 0000", bus.o_busy, bus.o_done, bus.o_result);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mul(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp);
        drive_start(2'b00, a, b);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            n_tests++;
            if (bus.o_busy !== (k <= 16) || bus.o_done !== (k == 17)) begin
                n_fail++;
                $display("FAIL mul_timing %h*%h cycle T+%0d busy=%b done=%b", a, b, k, bus.o_busy, bus.o_done);
            end
        end
        n_tests++;
        if (bus.o_result !== exp) begin
            n_fail++;
            $display("FAIL mul_result %h*%h got %h expected %h", a, b, bus.o_result, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [1:0]  ops [3] = '{2'b01, 2'b10, 2'b01};
        logic [15:0] as  [3] = '{16'd100, 16'd100, 16'hFFFF};
        logic [15:0] bs  [3] = '{16'd7, 16'd7, 16'd2};
        logic [15:0] exps[3] = '{16'h000E, 16'h0002, 16'h7FFF};
        drive_start(ops[0], as[0], bs[0]);
        for (int i = 0; i < 3; i++) begin
            for (int k = 1; k <= 17; k++) begin
                @(negedge clk);
                n_tests++;
                if (bus.o_busy !== (k <= 16) || bus.o_done !== (k == 17)) begin
                    n_fail++;
                    $display("FAIL b2b_timing op%0d cycle T+%0d busy=%b done=%b", i, k, bus.o_busy, bus.o_done);
                end
            end
            n_tests++;
            if (bus.o_result !== exps[i]) begin
                n_fail++;
                $display("FAIL b2b_result op%0d got %h expected %h", i, bus.o_result, exps[i]);
            end
            if (i < 2) drive_start(ops[i+1], as[i+1], bs[i+1]);
        end
        @(negedge clk);
        n_tests++;
        if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle busy=%b done=%b expected 0 0", bus.o_busy, bus.o_done);
        end
    endtask

    task automatic test_flush();
        drive_start(2'b00, 16'd3, 16'd5);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            n_tests++;
            if (bus.o_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL flush_busy cycle T+%0d busy=%b expected 1", k, bus.o_busy);
            end
            if (k == 5) begin
                bus.i_start = 1'b1; bus.i_op = 2'b00; bus.i_r1data = 16'd7; bus.i_r2data = 16'd7;
            end
            if (k == 6) bus.i_start = 1'b0;
            if (k == 8) bus.i_flush = 1'b1;
        end
        @(negedge clk);
        bus.i_flush = 1'b0;
        n_tests++;
        if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 || bus.o_result !== 16'h7FFF) begin
            n_fail++;
            $display("FAIL flush_abort busy=%b done=%b result=%h expected 0 0 7fff", bus.o_busy, bus.o_done, bus.o_result);
        end
        for (int k = 10; k <= 26; k++) begin
            @(negedge clk);
            n_tests++;
            if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_result !== 16'h7FFF) begin
                n_fail++;
                $display("FAIL flush_quiet cycle T+%0d busy=%b done=%b result=%h", k, bus.o_busy, bus.o_done, bus.o_result);
            end
        end
    endtask

    task automatic test_rst_mid();
        drive_start(2'b01, 16'd100, 16'd7);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_tests++;
        if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 || bus.o_result !== 16'h0000) begin
            n_fail++;
            $display("FAIL rst_mid busy=%b done=%b result=%h expected 0 0 0000", bus.o_busy, bus.o_done, bus.o_result);
        end
        drive_start(2'b01, 16'd9, 16'd3);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            n_tests++;
            if (bus.o_busy !== (k <= 16) || bus.o_done !== (k == 17)) begin
                n_fail++;
                $display("FAIL rst_div_timing cycle T+%0d busy=%b done=%b", k, bus.o_busy, bus.o_done);
            end
        end
        n_tests++;
        if (bus.o_result !== 16'h0003) begin
            n_fail++;
            $display("FAIL rst_div_result got %h expected 0003", bus.o_result);
        end
        @(negedge clk);
    endtask

    task automatic test_zero_latency(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        drive_start(op, a, b);
        @(negedge clk);
        n_tests++;
        if (bus.o_done !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_result !== 16'h0000) begin
            n_fail++;
            $display("FAIL zero_lat op=%b busy=%b done=%b result=%h expected 0 1 0000", op, bus.o_busy, bus.o_done, bus.o_result);
        end
        @(negedge clk);
        n_tests++;
        if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_lat_after op=%b busy=%b done=%b expected 0 0", op, bus.o_busy, bus.o_done);
        end
    endtask

    initial begin
        bus.i_start  = 1'b0;
        bus.i_op     = 2'b00;
        bus.i_r1data = '0;
        bus.i_r2data = '0;
        bus.i_flush  = 1'b0;
        test_reset();
        test_mul(16'd3, 16'd5, 16'h000F);
        test_mul(16'h0100, 16'h0100, 16'h0000);
        test_mul(16'hFFFF, 16'h0003, 16'hFFFD);
        test_back_to_back();
        test_flush();
        test_rst_mid();
        test_zero_latency(2'b01, 16'd42, 16'd0);
        test_zero_latency(2'b10, 16'd42, 16'd0);
        test_zero_latency(2'b11, 16'd42, 16'd5);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
